// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
//   Round-robin arbiter that merges CNT master request channels onto one
//   slave request channel. Every grant pushes the winner's index into a
//   tag FIFO; the in-order slave responses are steered back to the master
//   named by the FIFO head.
//
//   Optional feature macro: MEM_ARB_CREDIT_EN
//     defined   : per-master credit counters cap each master at
//                 MAX_OUTSTANDING requests in flight
//     undefined : every valid master is eligible; only QUEUE_DEPTH bounds
//                 the total in flight
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   master_req_*_i/_o        per-master request  (valid/ready/data[ADDR_WIDTH])
//   master_resp_*_o/_i       per-master response (valid/ready/data[DATA_WIDTH])
//   slave_req_*_o/_i         arbitrated request to memory
//   slave_resp_*_i/_o        in-order response from memory
module mem_arbiter_rr #(
  parameter int CNT             = 2,
  parameter int QUEUE_DEPTH     = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CNT-1:0]                      master_req_valid_i,
  output logic [CNT-1:0]                      master_req_ready_o,
  input  logic [CNT-1:0][ADDR_WIDTH-1:0]      master_req_data_i,
  output logic [CNT-1:0]                      master_resp_valid_o,
  input  logic [CNT-1:0]                      master_resp_ready_i,
  output logic [CNT-1:0][DATA_WIDTH-1:0]      master_resp_data_o,
  output logic                                slave_req_valid_o,
  input  logic                                slave_req_ready_i,
  output logic [ADDR_WIDTH-1:0]               slave_req_data_o,
  input  logic                                slave_resp_valid_i,
  output logic                                slave_resp_ready_o,
  input  logic [DATA_WIDTH-1:0]               slave_resp_data_i
);

  localparam int IDX_W = (CNT > 1) ? $clog2(CNT) : 1;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  if (CNT < 1 || QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 ||
      MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > QUEUE_DEPTH) begin : g_bad_cfg
    $error("mem_arbiter_rr: illegal parameter combination");
  end

  logic [IDX_W-1:0]                  ptr_q, ptr_d, sel, cand, head;
  logic [QUEUE_DEPTH-1:0][IDX_W-1:0] tag_q;
  logic [PTR_W-1:0]                  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OCC_W-1:0]                  occ_q, occ_d;
  logic [CNT-1:0]                    elig;
  logic                              any_elig, full, empty, push, pop;

`ifdef MEM_ARB_CREDIT_EN
  localparam int CR_W = $clog2(MAX_OUTSTANDING + 1);
  logic [CNT-1:0][CR_W-1:0] credit_q, credit_d;

  for (genvar i = 0; i < CNT; i++) begin : g_credit
    assign elig[i] = master_req_valid_i[i] &&
                     (credit_q[i] < CR_W'(MAX_OUTSTANDING));

    // Grant and return to the same master in one cycle cancel out.
    always_comb begin
      credit_d[i] = credit_q[i];
      case ({push && (sel == IDX_W'(i)), pop && (head == IDX_W'(i))})
        2'b10:   credit_d[i] = credit_q[i] + CR_W'(1);
        2'b01:   credit_d[i] = credit_q[i] - CR_W'(1);
        default: ;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) credit_q[i] <= '0;
      else     credit_q[i] <= credit_d[i];
    end
  end
`else
  assign elig = master_req_valid_i;
`endif

  // First eligible index at or after ptr, wrapping modulo CNT.
  always_comb begin
    sel      = '0;
    cand     = '0;
    any_elig = 1'b0;
    for (int k = 0; k < CNT; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % CNT);
      if (!any_elig && elig[cand]) begin
        any_elig = 1'b1;
        sel      = cand;
      end
    end
  end

  assign full  = (occ_q == OCC_W'(QUEUE_DEPTH));
  assign empty = (occ_q == '0);
  assign head  = tag_q[rptr_q];

  // Full blocks the push even when a pop lands in the same cycle, so the
  // response side never feeds combinationally into slave_req_valid_o.
  assign slave_req_valid_o  = any_elig && !full && !rst;
  assign slave_req_data_o   = master_req_data_i[sel];
  assign push               = slave_req_valid_o && slave_req_ready_i;

  assign slave_resp_ready_o = master_resp_ready_i[head] && !empty && !rst;
  assign pop                = slave_resp_valid_i && slave_resp_ready_o;

  for (genvar i = 0; i < CNT; i++) begin : g_lane
    assign master_req_ready_o[i]  = push && (sel == IDX_W'(i));
    assign master_resp_valid_o[i] = slave_resp_valid_i && !empty && (head == IDX_W'(i));
    assign master_resp_data_o[i]  = slave_resp_data_i;
  end

  always_comb begin
    ptr_d  = ptr_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (push) begin
      ptr_d  = (sel == IDX_W'(CNT - 1)) ? '0 : sel + IDX_W'(1);
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (pop) rptr_d = rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  // Tag storage needs no reset: entries are only read while occupancy > 0.
  always_ff @(posedge clk) begin
    if (push) tag_q[wptr_q] <= sel;
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
`timescale 1ns/1ps
module tb_mem_arbiter_rr;
  localparam int CNT = 3, QD = 4, AW = 16, DW = 16, MAXO = 2;
`ifdef MEM_ARB_CREDIT_EN
  localparam int CREDIT = 1;
`else
  localparam int CREDIT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [CNT-1:0] mv, mrdy, mrv, mrr;
  logic [CNT-1:0][AW-1:0] md;
  logic [CNT-1:0][DW-1:0] mrd;
  logic srv, srr, srpv, srpr;
  logic [AW-1:0] srd;
  logic [DW-1:0] srpd;

  always #5 clk = ~clk;

  mem_arbiter_rr #(.CNT(CNT), .QUEUE_DEPTH(QD), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                   .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .master_req_valid_i(mv), .master_req_ready_o(mrdy), .master_req_data_i(md),
    .master_resp_valid_o(mrv), .master_resp_ready_i(mrr), .master_resp_data_o(mrd),
    .slave_req_valid_o(srv), .slave_req_ready_i(srr), .slave_req_data_o(srd),
    .slave_resp_valid_i(srpv), .slave_resp_ready_o(srpr), .slave_resp_data_i(srpd)
  );

  int vectors = 0, miscompares = 0, cyc = 0;

  // Reference model: the list of outstanding issuers in issue order plus
  // the round-robin start index.
  int mq[$];
  int mptr = 0;
  bit e_sv, e_push, e_pop, e_srr;
  int e_sel;
  bit [CNT-1:0] e_mrdy, e_mrv;
  logic [3*CNT+1:0] exp_ctl;
  wire  [3*CNT+1:0] obs = {srv, mrdy, mrv, srpr};

`ifdef MEM_ARB_CREDIT_EN
  function automatic int credit_of(int m);
    int n = 0;
    foreach (mq[j]) if (mq[j] == m) n++;
    return n;
  endfunction
`endif

  function automatic void model_eval();
    bit [CNT-1:0] el;
    bit found;
    int idx;
    for (int i = 0; i < CNT; i++) begin
      el[i] = mv[i];
`ifdef MEM_ARB_CREDIT_EN
      if (credit_of(i) >= MAXO) el[i] = 1'b0;
`endif
    end
    found = 1'b0;
    e_sel = 0;
    for (int k = 0; k < CNT; k++) begin
      idx = (mptr + k) % CNT;
      if (!found && el[idx]) begin found = 1'b1; e_sel = idx; end
    end
    e_sv   = found && (mq.size() < QD) && !rst;
    e_push = e_sv && srr;
    e_mrdy = '0;
    e_mrdy[e_sel] = e_push;
    e_mrv  = '0;
    e_srr  = 1'b0;
    if (mq.size() > 0) begin
      e_mrv[mq[0]] = srpv;
      e_srr = mrr[mq[0]] && !rst;
    end
    e_pop   = e_srr && srpv;
    exp_ctl = {e_sv, e_mrdy, e_mrv, e_srr};
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mptr = 0;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (e_push) begin mq.push_back(e_sel); mptr = (e_sel + 1) % CNT; end
    end
    cyc++;
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic idle();
    mv = '0; md = '0; srr = 1'b1; srpv = 1'b0; srpd = '0; mrr = '1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; mv = '1; srpv = 1'b1;
    for (int i = 0; i < CNT; i++) md[i] = AW'($urandom);
    tick();
    repeat (2) begin
      settle();
      if (obs !== '0) begin miscompares++; $display("FAIL reset_out cyc=%0d got=%b exp=0", cyc, obs); end
      vectors++;
      tick();
    end
    rst = 1'b0; idle();
    settle();
    if (obs !== exp_ctl || obs !== '0) begin miscompares++; $display("FAIL reset_idle cyc=%0d got=%b exp=0", cyc, obs); end
    vectors++;
    tick();
  endtask

  task automatic test_fairness();
    int g = 0, rsp = 0;
    int pm[$], pt[$];
    logic [CNT-1:0] eg;
    do_reset();
    mv = '1; md[0] = 16'h10; md[1] = 16'h20; md[2] = 16'h30;
    for (int c = 0; c < 20; c++) begin
      if (c == 12) mv = '0;
      srpv = 1'b0;
      if (pm.size() > 0 && cyc >= pt[0] + 2) begin srpv = 1'b1; srpd = 16'hA000 + DW'(rsp); end
      settle();
      if (obs !== exp_ctl) begin miscompares++; $display("FAIL fair_ctl cyc=%0d got=%b exp=%b", cyc, obs, exp_ctl); end
      vectors++;
      if (srv && srr) begin
        eg = '0; eg[g % CNT] = 1'b1;
        if (mrdy !== eg || srd !== AW'(16'h10 * (g % CNT + 1))) begin
          miscompares++; $display("FAIL fair_grant n=%0d got=%b/%h exp=%b/%h", g, mrdy, srd, eg, 16'h10 * (g % CNT + 1));
        end
        vectors++;
        pm.push_back(g % CNT); pt.push_back(cyc); g++;
      end
      if (srpv) begin
        eg = '0; eg[pm[0]] = 1'b1;
        if (mrv !== eg || mrd[pm[0]] !== srpd) begin
          miscompares++; $display("FAIL fair_resp cyc=%0d got=%b/%h exp=%b/%h", cyc, mrv, mrd[pm[0]], eg, srpd);
        end
        vectors++;
        if (srpr) begin void'(pm.pop_front()); void'(pt.pop_front()); rsp++; end
      end
      tick();
    end
    if (g != 12 || rsp != 12) begin miscompares++; $display("FAIL fair_count got=%0d/%0d exp=12/12", g, rsp); end
    vectors++;
    idle();
  endtask

  task automatic test_fifo_full();
    int fires = 0;
    do_reset();
    mv = (CREDIT != 0) ? 3'b011 : 3'b001;
    for (int i = 0; i < CNT; i++) md[i] = AW'($urandom);
    repeat (8) begin
      settle();
      if (obs !== exp_ctl) begin miscompares++; $display("FAIL full_ctl cyc=%0d got=%b exp=%b", cyc, obs, exp_ctl); end
      vectors++;
      if (srv && srr) fires++;
      tick();
    end
    if (fires != QD) begin miscompares++; $display("FAIL full_fires got=%0d exp=%0d", fires, QD); end
    vectors++;
    settle();
    if (srv !== 1'b0) begin miscompares++; $display("FAIL full_stall got=%b exp=0", srv); end
    vectors++;
    tick();
  endtask

  task automatic test_push_pop_full();
    srpv = 1'b1; srpd = DW'($urandom);
    settle();
    if (obs !== exp_ctl) begin miscompares++; $display("FAIL pp_ctl cyc=%0d got=%b exp=%b", cyc, obs, exp_ctl); end
    vectors++;
    if (srv !== 1'b0 || srpr !== 1'b1) begin miscompares++; $display("FAIL pp_block got=%b%b exp=01", srv, srpr); end
    vectors++;
    tick();
    srpv = 1'b0;
    settle();
    if (srv !== 1'b1 || obs !== exp_ctl) begin miscompares++; $display("FAIL pp_reopen got=%b exp=1", srv); end
    vectors++;
    tick();
    settle();
    if (srv !== 1'b0 || obs !== exp_ctl) begin miscompares++; $display("FAIL pp_refull got=%b exp=0", srv); end
    vectors++;
    tick();
  endtask

  task automatic test_credit();
    int f0 = 0, f1 = 0;
    logic [CNT-1:0] want;
    do_reset();
    mv = 3'b001;
    for (int i = 0; i < CNT; i++) md[i] = AW'($urandom);
    repeat (6) begin
      settle();
      if (obs !== exp_ctl) begin miscompares++; $display("FAIL cred_ctl cyc=%0d got=%b exp=%b", cyc, obs, exp_ctl); end
      vectors++;
      if (srv && srr) f0++;
      tick();
    end
    if (f0 != ((CREDIT != 0) ? MAXO : QD)) begin miscompares++; $display("FAIL cred_m0 got=%0d exp=%0d", f0, (CREDIT != 0) ? MAXO : QD); end
    vectors++;
    mv = 3'b011;
    repeat (4) begin
      settle();
      if (obs !== exp_ctl) begin miscompares++; $display("FAIL cred_ctl cyc=%0d got=%b exp=%b", cyc, obs, exp_ctl); end
      vectors++;
      if (mrdy[1]) f1++;
      tick();
    end
    if (f1 != ((CREDIT != 0) ? MAXO : 0)) begin miscompares++; $display("FAIL cred_m1 got=%0d exp=%0d", f1, (CREDIT != 0) ? MAXO : 0); end
    vectors++;
    srpv = 1'b1; srpd = DW'($urandom);
    settle();
    if (mrv !== 3'b001 || obs !== exp_ctl) begin miscompares++; $display("FAIL cred_resp got=%b exp=001", mrv); end
    vectors++;
    tick();
    srpv = 1'b0;
    want = (CREDIT != 0) ? 3'b001 : 3'b010;
    settle();
    if (mrdy !== want) begin miscompares++; $display("FAIL cred_reenable got=%b exp=%b", mrdy, want); end
    vectors++;
    tick();
    idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    mv = 3'b010; md[1] = 16'h1234;
    settle();
    if (mrdy !== 3'b010 || srd !== 16'h1234) begin miscompares++; $display("FAIL bp_issue got=%b/%h exp=010/1234", mrdy, srd); end
    vectors++;
    tick();
    mv = '0; srpv = 1'b1; srpd = 16'h5a5a; mrr = 3'b101;
    repeat (3) begin
      settle();
      if (srpr !== 1'b0 || mrv !== 3'b010 || obs !== exp_ctl) begin
        miscompares++; $display("FAIL bp_hold cyc=%0d got=%b/%b exp=0/010", cyc, srpr, mrv);
      end
      vectors++;
      tick();
    end
    mrr = '1;
    settle();
    if (srpr !== 1'b1 || mrd[1] !== 16'h5a5a) begin miscompares++; $display("FAIL bp_release got=%b/%h exp=1/5a5a", srpr, mrd[1]); end
    vectors++;
    tick();
    settle();
    if (srpr !== 1'b0 || mrv !== '0) begin miscompares++; $display("FAIL empty_resp got=%b/%b exp=0/000", srpr, mrv); end
    vectors++;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mv = '1;
    repeat (3) begin
      settle();
      if (obs !== exp_ctl) begin miscompares++; $display("FAIL rmid_ctl cyc=%0d got=%b exp=%b", cyc, obs, exp_ctl); end
      vectors++;
      tick();
    end
    mv = '0; rst = 1'b1;
    settle();
    if (srv !== 1'b0 || mrdy !== '0 || srpr !== 1'b0) begin miscompares++; $display("FAIL rmid_during got=%b exp=0", obs); end
    vectors++;
    tick();
    rst = 1'b0; srpv = 1'b1; mv = 3'b110;
    settle();
    if (srpr !== 1'b0 || mrv !== '0 || mrdy !== 3'b010) begin
      miscompares++; $display("FAIL rmid_after got=%b/%b/%b exp=0/000/010", srpr, mrv, mrdy);
    end
    vectors++;
    tick();
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < CNT; i++) begin
        mv[i]  = 1'($urandom_range(0, 1));
        md[i]  = AW'($urandom);
        mrr[i] = ($urandom_range(0, 3) != 0);
      end
      srr  = ($urandom_range(0, 3) != 0);
      srpv = 1'($urandom_range(0, 1));
      srpd = DW'($urandom);
      rst  = ($urandom_range(0, 79) == 0);
      settle();
      if (obs !== exp_ctl) begin miscompares++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", cyc, obs, exp_ctl); end
      vectors++;
      if (e_sv) begin
        if (srd !== md[e_sel]) begin miscompares++; $display("FAIL rnd_req_data cyc=%0d got=%h exp=%h", cyc, srd, md[e_sel]); end
        vectors++;
      end
      if (mrd !== {CNT{srpd}}) begin miscompares++; $display("FAIL rnd_resp_data cyc=%0d got=%h exp=%h", cyc, mrd, {CNT{srpd}}); end
      vectors++;
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fairness();
    test_fifo_full();
    test_push_pop_full();
    test_credit();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Round-robin memory arbiter that multiplexes `CNT` master request channels onto one slave request channel and routes in-order slave responses back to the issuing master. It is the parametrised successor to the fixed-priority arbiter in the memory subsystem. Each grant is recorded in an internal tag FIFO, so responses return in issue order. Optional per-master credit limits stop one master from filling the FIFO.

## Interface
Parameters:
- `CNT`, 2: number of master channels; ≥1.
- `QUEUE_DEPTH`, 4: tag FIFO entries, i.e. max outstanding requests in total; power of two, ≥2.
- `ADDR_WIDTH`, 32: request payload width.
- `DATA_WIDTH`, 32: response payload width.
- `MAX_OUTSTANDING`, 2: per-master credit limit; used only with `MEM_ARB_CREDIT_EN`; 1..`QUEUE_DEPTH`.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `master_req[CNT]`  decoupled.in  `ADDR_WIDTH`  per-master request; valid/ready/data.
- `master_resp[CNT]`  decoupled.out  `DATA_WIDTH`  per-master response.
- `slave_req`  decoupled.out  `ADDR_WIDTH`  arbitrated request to memory.
- `slave_resp`  decoupled.in  `DATA_WIDTH`  in-order response from memory.
- Index width: `IDX_W = max(1, $clog2(CNT))`.

## Operation
- **Eligibility.** Master i is eligible when `master_req[i].valid` is high and, with credits on, `credit[i] < MAX_OUTSTANDING`.
- **Grant.**
  - `sel` is the first eligible index found by scanning `ptr`, `ptr+1`, … mod `CNT`.
  - Grant is combinational.
  - `slave_req.data` = `master_req[sel].data`.
- **Request valid.** `slave_req.valid` = any eligible && `!fifo_full` && `!rst`.
- **Request ready.** `master_req[i].ready` = `slave_req.fire() && sel == i`. This is never asserted for a non-selected or ineligible master.
- **On request fire:**
  - push `sel` into the tag FIFO;
  - `ptr <= (sel + 1) mod CNT`;
  - with credits on, `credit[sel]++`.
- **Pointer hold.** `ptr` does not change in cycles without a fire.
- **Response routing:**
  - `head` is the FIFO head tag.
  - `master_resp[i].valid` = `slave_resp.valid && !fifo_empty && head == i`.
  - `master_resp[i].data` = `slave_resp.data` for all i.
  - `slave_resp.ready` = `master_resp[head].ready && !fifo_empty && !rst`.
- **On response fire:** pop the FIFO; with credits on, `credit[head]--`.
- **Simultaneous increment/decrement.** If the same master is incremented and decremented in one cycle, its credit is unchanged.
- **FIFO:**
  - circular, with read/write pointers of `$clog2(QUEUE_DEPTH)` bits that wrap modulo depth;
  - occupancy counter is `$clog2(QUEUE_DEPTH)+1` bits.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Push is blocked when full, even if a pop happens in the same cycle. There is no path from `slave_resp` into `slave_req.valid`.
- **Empty FIFO.** A response arriving while the FIFO is empty is never accepted (ready held low). This is a protocol error by the slave.
- **Reset values:**
  - `ptr` = 0, FIFO empty, all credits = 0.
  - `slave_req.valid` = 0, `slave_resp.ready` = 0, all `master_req[i].ready` = 0, all `master_resp[i].valid` = 0.
- **Reset mid-operation.** Outstanding tags are discarded. The slave must be reset in the same cycle.

## Timing
- Request path is zero latency: master valid → slave valid in the same cycle, combinational.
- A response is delivered combinationally in the cycle `slave_resp.valid` is high.
- Sustained throughput is one request and one response per cycle while the FIFO is neither full nor empty.
- A granted master gets lowest priority from the next cycle. With N masters continuously valid, each is granted exactly once every N fires.
- Full: the cycle after the `QUEUE_DEPTH`-th outstanding push, `slave_req.valid` = 0 until a pop has occurred on an earlier edge.
- Decisions are made only from registered state plus current-cycle inputs. There are no combinational loops through `ready`.

## Configuration
- `MEM_ARB_CREDIT_EN` defined:
  - a per-master credit counter of `$clog2(MAX_OUTSTANDING+1)` bits is instantiated;
  - a master at its limit is skipped by the round-robin scan and its ready stays 0.
- Undefined:
  - no counters; all valid masters are eligible;
  - the total outstanding count is bounded only by `QUEUE_DEPTH`;
  - `MAX_OUTSTANDING` is ignored.

## Test plan
- **Round-robin fairness.**
  - Stimulus: CNT=3; masters 0, 1, 2 continuously valid with data 0x10/0x20/0x30; slave always ready and responds 2 cycles later.
  - Required: grants in order 0, 1, 2, 0, 1, 2; each response is returned to its issuer in issue order.
- **FIFO full.**
  - Stimulus: QUEUE_DEPTH=4, slave_resp idle, master 0 continuously valid.
  - Required: exactly 4 fires, then `slave_req.valid` = 0. One response pops a tag; the next cycle allows one more fire.
- **Credit limit (`MEM_ARB_CREDIT_EN`).**
  - Stimulus: MAX_OUTSTANDING=2; masters 0 and 1 valid; no responses.
  - Required: grants 0, 1, 0, 1, then master 0 blocked and only master 1's credits exhausted too; a response to master 0 re-enables master 0 next cycle.
- **Response backpressure.**
  - Stimulus: head tag = 1, `master_resp[1].ready` = 0 for 3 cycles.
  - Required: `slave_resp.ready` = 0 for those 3 cycles, the FIFO does not pop, and `master_resp[0].valid` stays 0.
- **Simultaneous push/pop at full.**
  - Stimulus: FIFO full; response fires in the same cycle a master is valid.
  - Required: no push that cycle; occupancy 3 next cycle; push allowed after.
- **Reset mid-operation.**
  - Stimulus: 3 tags outstanding; assert `rst` for 1 cycle.
  - Required: next cycle FIFO empty, `ptr` = 0, `slave_resp.ready` = 0; the first grant after reset goes to the lowest valid index.
